// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: flow-controlled front end for the combinational 4-bit alu.
// Requests are buffered in a DEPTH-entry FIFO, the head drives the alu, and
// the alu result is captured with its opcode into a single output register.
module alu_issue_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [1:0]       out_sel,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem_a   [DEPTH];
  logic [WIDTH-1:0] r_mem_b   [DEPTH];
  logic [1:0]       r_mem_sel [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic [1:0]       r_out_sel;

  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_empty  = (r_count == '0);
  // in_ready looks only at the FIFO fill level, never at the consumer side.
  assign in_ready = (r_count != CNT_FULL);
  assign w_push   = in_valid && in_ready;
  // Pop when there is a head entry and the result register is free or draining.
  assign w_pop    = !w_empty && (!r_out_valid || out_ready);

  // Head of the FIFO feeds the alu; zeroed while empty so reset clears it at once.
  assign alu_a   = w_empty ? '0 : r_mem_a[r_rptr];
  assign alu_b   = w_empty ? '0 : r_mem_b[r_rptr];
  assign alu_sel = w_empty ? '0 : r_mem_sel[r_rptr];

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_sel    = r_out_sel;
  assign busy       = !w_empty || r_out_valid;

  // Request storage: written at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wptr]   <= in_a;
      r_mem_b[r_wptr]   <= in_b;
      r_mem_sel[r_wptr] <= in_sel;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Result register: capture alu output on pop, clear valid once consumed,
  // hold data during a stall or after the last result drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_sel    <= '0;
    end else if (w_pop) begin
      r_out_valid  <= 1'b1;
      r_out_result <= alu_out;
      r_out_sel    <= alu_sel;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: alu model on the alu ports, queue-based scoreboard
// on both handshakes, a vector table, directed corner sequences and random traffic.
module tb_alu_issue_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [3:0] in_a, in_b;
  logic [1:0] in_sel;
  logic [3:0] alu_a, alu_b, alu_out;
  logic [1:0] alu_sel;
  logic       out_valid, out_ready;
  logic [3:0] out_result;
  logic [1:0] out_sel;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct { logic [3:0] a; logic [3:0] b; logic [1:0] sel; } req_t;
  typedef struct { logic [3:0] a; logic [3:0] b; logic [1:0] sel; logic [3:0] exp; } vec_t;

  req_t q[$];

  alu_issue_ctrl #(.WIDTH(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_sel(out_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  // Combinational alu attached to the DUT.
  always_comb begin
    alu_out = '0;
    case (alu_sel)
      2'b00: alu_out = alu_a + alu_b;
      2'b01: alu_out = alu_a - alu_b;
      2'b10: alu_out = alu_a & alu_b;
      default: alu_out = alu_a | alu_b;
    endcase
  end

  function automatic logic [3:0] ref_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    int x;
    case (s)
      2'd0: x = (int'(a) + int'(b)) % 16;
      2'd1: x = (int'(a) - int'(b) + 16) % 16;
      2'd2: x = int'(a & b);
      default: x = int'(a | b);
    endcase
    return 4'(x);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Scoreboard: q holds every accepted request not yet delivered.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'((q.size() - int'(out_valid)) != DEPTH));
      if (out_valid) chk("result_has_request", 32'(q.size() > 0), 32'd1);
      if (out_valid && out_ready && q.size() > 0) begin
        chk("sb_result", 32'(out_result), 32'(ref_op(q[0].a, q[0].b, q[0].sel)));
        chk("sb_sel", 32'(out_sel), 32'(q[0].sel));
        void'(q.pop_front());
      end
      if (in_valid && in_ready) q.push_back('{in_a, in_b, in_sel});
    end
  end

  // Offer one request (called just after a rising edge); returns once accepted.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    bit ok = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_sel = s;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    if (!ok) chk("send_timeout", 32'(ok), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(posedge clk); #1;
      done = !busy && !out_valid;
    end
    chk("idle_timeout", 32'(done), 32'd1);
  endtask

  task automatic get_result(input string nm, input logic [3:0] exp, input logic [1:0] s);
    bit seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = out_valid;
      if (seen) begin
        chk({nm, "_result"}, 32'(out_result), 32'(exp));
        chk({nm, "_sel"}, 32'(out_sel), 32'(s));
      end
    end
    chk({nm, "_valid"}, 32'(seen), 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{4'hA, 4'h2, 2'd0, 4'hC}, '{4'hA, 4'h2, 2'd1, 4'h8},
      '{4'hA, 4'h2, 2'd2, 4'h2}, '{4'hA, 4'h2, 2'd3, 4'hA},
      '{4'hF, 4'h1, 2'd0, 4'h0}, '{4'h2, 4'hA, 2'd1, 4'h8},
      '{4'h3, 4'h5, 2'd3, 4'h7}, '{4'h5, 4'h3, 2'd1, 4'h2},
      '{4'hC, 4'hA, 2'd2, 4'h8}, '{4'h0, 4'h1, 2'd1, 4'hF}
    };
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_result", 32'(out_result), 0);
    chk("rst_out_sel", 32'(out_sel), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_alu", {20'd0, alu_a, alu_b, 2'd0, alu_sel}, 0);
    rst_n = 1'b1;

    // Single op latency: push at edge N, result valid after edge N+1.
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 4'hA; in_b = 4'h2; in_sel = 2'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t1_valid_early", 32'(out_valid), 0);
    chk("t1_alu_head", {24'd0, alu_a, alu_b}, 32'hA2);
    chk("t1_busy", 32'(busy), 1);
    @(posedge clk); #1;
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_result", 32'(out_result), 32'hC);
    chk("t1_sel", 32'(out_sel), 0);
    @(posedge clk); #1;
    chk("t1_valid_drop", 32'(out_valid), 0);
    chk("t1_busy_idle", 32'(busy), 0);
    chk("t1_result_hold", 32'(out_result), 32'hC);

    // Back-to-back sweep; scoreboard checks order, in_ready must stay high.
    for (int i = 0; i < 4; i++) begin
      send(4'hA, 4'h2, 2'(i));
      chk("t2_in_ready", 32'(in_ready), 1);
      if (i > 0) chk("t2_streaming", 32'(out_valid), 1);
    end
    wait_idle();

    // Vector table, one request at a time.
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].sel);
      get_result("tbl", vecs[i].exp, vecs[i].sel);
      wait_idle();
    end

    // Backpressure: DEPTH+1 accepted, sixth refused, head result held.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(4'(i + 1), 4'h1, 2'd0);
    chk("t3_full", 32'(in_ready), 0);
    in_valid = 1'b1; in_a = 4'h7; in_b = 4'h1; in_sel = 2'd0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t3_in_ready_low", 32'(in_ready), 0);
      chk("t3_hold_valid", 32'(out_valid), 1);
      chk("t3_hold_result", 32'(out_result), 32'h2);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_in_ready_back", 32'(in_ready), 1);
    wait_idle();

    // Ten more requests to wrap the pointers again.
    for (int i = 0; i < 10; i++) send(4'($urandom_range(15)), 4'($urandom_range(15)), 2'($urandom_range(3)));
    wait_idle();

    // Simultaneous push and pop at count=2 with a held result.
    out_ready = 1'b0;
    send(4'h1, 4'h2, 2'd0);
    send(4'h4, 4'h4, 2'd0);
    send(4'h6, 4'h1, 2'd1);
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 4'h9; in_b = 4'h3; in_sel = 2'd2;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t5_next_result", 32'(out_result), 32'h8);
    chk("t5_valid", 32'(out_valid), 1);
    send(4'h1, 4'h1, 2'd3);
    send(4'h2, 4'h2, 2'd0);
    chk("t5_count_full", 32'(in_ready), 0);
    out_ready = 1'b1;
    wait_idle();

    // Reset mid-operation clears outputs immediately, no stale results after.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'(i + 8), 4'h3, 2'(i));
    chk("t6_pre_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_result", 32'(out_result), 0);
    chk("t6_alu", {20'd0, alu_a, alu_b, 2'd0, alu_sel}, 0);
    chk("t6_busy", 32'(busy), 0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(4'h3, 4'h5, 2'd3);
    get_result("t6_new", 4'h7, 2'd3);
    wait_idle();

    // Random traffic against the scoreboard.
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom_range(1));
      in_a = 4'($urandom_range(15));
      in_b = 4'($urandom_range(15));
      in_sel = 2'($urandom_range(3));
      out_ready = ($urandom_range(3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_idle();
    chk("final_drained", 32'(q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Upstream issue stage for the 4-bit combinational alu. It accepts operation requests (A, B, ALU_Sel) over a valid/ready handshake and buffers them in a small FIFO. It drives the FIFO head onto the alu inputs, registers ALU_Out together with its opcode tag, and presents results in order over a valid/ready handshake. This gives the purely combinational alu a flow-controlled, pipelined front end.

Parameters:
WIDTH, 4, operand and result width; must equal the alu data width.
DEPTH, 4, request FIFO entries; power of two, at least 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  request valid.
in_ready  output  1  FIFO can accept a request.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_sel  input  2  operation select.
alu_a  output  WIDTH  to alu A.
alu_b  output  WIDTH  to alu B.
alu_sel  output  2  to alu ALU_Sel.
alu_out  input  WIDTH  from alu ALU_Out.
out_valid  output  1  result register holds a result.
out_ready  input  1  consumer accepts the result.
out_result  output  WIDTH  captured alu result.
out_sel  output  2  opcode that produced out_result.
busy  output  1  high when the FIFO count is nonzero or out_valid is high.

Behaviour:
- Reset (asynchronous, takes effect immediately): FIFO count, read pointer and write pointer = 0; out_valid = 0; out_result = 0; out_sel = 0. With the FIFO empty, alu_a, alu_b and alu_sel = 0, in_ready = 1 and busy = 0.
- Reset mid-operation flushes all buffered requests and any held result. No stale result appears after rst_n deasserts.
- Push: in_valid && in_ready; the {in_a, in_b, in_sel} entry is written at the write pointer on the clock edge.
- in_ready = (count != DEPTH). It does not depend combinationally on out_ready or on a same-cycle pop.
- The FIFO head drives alu_a, alu_b and alu_sel whenever count > 0; all three are 0 when the FIFO is empty. The alu is combinational, so alu_out is valid in the same cycle.
- Pop/capture: when count > 0 && (!out_valid || out_ready), on the clock edge:
  - out_result <= alu_out;
  - out_sel <= head sel;
  - out_valid <= 1;
  - the read pointer advances.
- When the FIFO is empty and out_ready && out_valid, out_valid <= 0 and out_result/out_sel hold their values.
- While out_valid && !out_ready, out_result and out_sel are held stable (stall).
- Latency: a request pushed at edge N into an empty FIFO with a free result register appears with out_valid at edge N+1. Sustained throughput is one result per cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Results are always delivered in request order, with no drops and no duplicates.
- Arithmetic is owned entirely by the alu. The team encoding is 00 add, 01 sub, 10 and, 11 or, all modulo 2^WIDTH with no carry or borrow output. This block never alters alu_out.
- Capacity: DEPTH requests buffered plus one held result, so DEPTH+1 requests can be accepted while out_ready = 0.

Test Plan:
1. Single op: after reset, push A=0xA, B=0x2, sel=00 with out_ready=1 -> out_valid high one cycle later, out_result=0xC, out_sel=00; busy returns to 0 on the following cycle.
2. Back-to-back sweep: push A=0xA, B=0x2 with sel 00, 01, 10, 11 on consecutive cycles, out_ready=1 -> results 0xC, 0x8, 0x2, 0xA in order, one per cycle, in_ready constantly 1.
3. Backpressure: out_ready=0, offer 6 requests -> 5 accepted, then in_ready=0; out_result holds the first result. Raise out_ready -> the remaining 4 drain in order and in_ready returns to 1 after the first pop.
4. Wrap-around: A=0xF, B=0x1, sel=00 -> 0x0. A=0x2, B=0xA, sel=01 -> 0x8. Additionally push and pop 10 requests to wrap the pointers twice -> order preserved.
5. Simultaneous push/pop at count=2 with out_valid=1 and out_ready=1 -> count stays 2 and the next result follows correctly.
6. Reset mid-operation: 3 requests buffered with out_valid=1, then drive rst_n low -> out_valid, out_result, alu_a, alu_b and alu_sel all go to 0 immediately, before the next clock edge. After release, a new request A=0x3, B=0x5, sel=11 yields 0x7 with no earlier results.
